// File: rtl/decoder_scan_if.sv
// Bundle of control inputs and strobe outputs for the decoder_scan line decoder.
interface decoder_scan_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
);
  localparam int N = 1 << SEL_W;

  logic               en;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [DWELL_W-1:0] dwell;
  logic [N-1:0]       d;
  logic [SEL_W-1:0]   idx;
  logic               wrap;

  modport master (
    output en, mode, sel, dwell,
    input  d, idx, wrap
  );

  modport slave (
    input  en, mode, sel, dwell,
    output d, idx, wrap
  );
endinterface

// File: rtl/decoder_scan.sv
// Registered one-hot line decoder with direct decode and a dwell-timed auto-scan mode,
// used as a digit/row strobe generator.
module decoder_scan #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4,
  parameter int REVERSE = 1
) (
  input logic           clk,
  input logic           rst_n,
  decoder_scan_if.slave bus
);
  localparam int N = 1 << SEL_W;

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} st_t;

  st_t                st, st_nxt;
  logic [N-1:0]       d_q, d_nxt;
  logic [SEL_W-1:0]   idx_q, idx_nxt;
  logic [DWELL_W-1:0] cnt_q, cnt_nxt;
  logic               wrap_q, wrap_nxt;
  logic [SEL_W-1:0]   idx_adv;

  // Legacy ordering N-1-i is just the bitwise complement of an SEL_W-bit index.
  function automatic logic [N-1:0] strobe(input logic [SEL_W-1:0] i);
    logic [SEL_W-1:0] m;
    logic [N-1:0]     oh;
    m     = (REVERSE != 0) ? ~i : i;
    oh    = '0;
    oh[m] = 1'b1;
    return oh;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      d_q    <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      st     <= st_nxt;
      d_q    <= d_nxt;
      idx_q  <= idx_nxt;
      cnt_q  <= cnt_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  always_comb begin
    st_nxt = IDLE;
    if (bus.en) st_nxt = bus.mode ? SCAN : DIRECT;
  end

  assign idx_adv = idx_q + 1'b1;

  always_comb begin
    d_nxt    = '0;
    idx_nxt  = idx_q;
    cnt_nxt  = '0;
    wrap_nxt = 1'b0;
    if (bus.en) begin
      if (!bus.mode) begin
        idx_nxt = bus.sel;
        d_nxt   = strobe(bus.sel);
      end else if (st != SCAN) begin
        // Entry edge: show the held index and start its dwell from zero.
        d_nxt = strobe(idx_q);
      end else if (cnt_q < bus.dwell) begin
        cnt_nxt = cnt_q + 1'b1;
        d_nxt   = strobe(idx_q);
      end else begin
        // Also covers dwell lowered below the running count.
        idx_nxt  = idx_adv;
        d_nxt    = strobe(idx_adv);
        wrap_nxt = &idx_q;
      end
    end
  end

  assign bus.d    = d_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: legacy and natural ordering instances share one stimulus stream.
module tb_decoder_scan;
  logic       clk = 1'b0;
  logic       rst_n, en, mode;
  logic [2:0] sel;
  logic [3:0] dwell;

  always #5 clk = ~clk;

  decoder_scan_if #(.SEL_W(3), .DWELL_W(4)) bus_r ();
  decoder_scan_if #(.SEL_W(3), .DWELL_W(4)) bus_f ();

  assign bus_r.en = en;     assign bus_f.en = en;
  assign bus_r.mode = mode; assign bus_f.mode = mode;
  assign bus_r.sel = sel;   assign bus_f.sel = sel;
  assign bus_r.dwell = dwell; assign bus_f.dwell = dwell;

  decoder_scan #(.SEL_W(3), .DWELL_W(4), .REVERSE(1)) dut_r (.clk(clk), .rst_n(rst_n), .bus(bus_r));
  decoder_scan #(.SEL_W(3), .DWELL_W(4), .REVERSE(0)) dut_f (.clk(clk), .rst_n(rst_n), .bus(bus_f));

  typedef struct {
    string      name;
    logic [7:0] er;
    logic [7:0] ef;
    logic [2:0] idx;
    logic       wrap;
  } exp_t;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] d_rev;
    logic [7:0] d_fwd;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[10];
  int   passed = 0;
  int   total  = 0;

  task automatic check_now(string nm, logic [7:0] er, logic [7:0] ef, logic [2:0] i, logic w);
    total++;
    if (bus_r.d === er && bus_f.d === ef && bus_r.idx === i && bus_f.idx === i &&
        bus_r.wrap === w && bus_f.wrap === w)
      passed++;
    else
      $display("FAIL %s: got d_rev=%h d_fwd=%h idx=%0d/%0d wrap=%b/%b, want d_rev=%h d_fwd=%h idx=%0d wrap=%b",
               nm, bus_r.d, bus_f.d, bus_r.idx, bus_f.idx, bus_r.wrap, bus_f.wrap, er, ef, i, w);
  endtask

  task automatic check_idx(string nm, logic on, logic [2:0] i, logic w);
    check_now(nm, on ? (8'h80 >> i) : 8'h00, on ? (8'h01 << i) : 8'h00, i, w);
  endtask

  task automatic push(string nm, logic [7:0] er, logic [7:0] ef, logic [2:0] i, logic w);
    exp_t e;
    e.name = nm; e.er = er; e.ef = ef; e.idx = i; e.wrap = w;
    sbq.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      total++;
      $display("FAIL tick: no expectation queued, got d_rev=%h idx=%0d", bus_r.d, bus_r.idx);
    end else begin
      e = sbq.pop_front();
      check_now(e.name, e.er, e.ef, e.idx, e.wrap);
    end
  endtask

  task automatic step(string nm, logic on, logic [2:0] i, logic w);
    push(nm, on ? (8'h80 >> i) : 8'h00, on ? (8'h01 << i) : 8'h00, i, w);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{3'd0, 8'h80, 8'h01};
    vt[1] = '{3'd1, 8'h40, 8'h02};
    vt[2] = '{3'd2, 8'h20, 8'h04};
    vt[3] = '{3'd3, 8'h10, 8'h08};
    vt[4] = '{3'd4, 8'h08, 8'h10};
    vt[5] = '{3'd5, 8'h04, 8'h20};
    vt[6] = '{3'd6, 8'h02, 8'h40};
    vt[7] = '{3'd7, 8'h01, 8'h80};
    vt[8] = '{3'd3, 8'h10, 8'h08};
    vt[9] = '{3'd6, 8'h02, 8'h40};

    rst_n = 1'b0; en = 1'b1; mode = 1'b1; sel = 3'd0; dwell = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check_idx("reset", 1'b0, 3'd0, 1'b0);

    en = 1'b0; rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step("disabled_after_reset", 1'b0, 3'd0, 1'b0);

    mode = 1'b0; en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      sel = vt[k].sel;
      push("direct_table", vt[k].d_rev, vt[k].d_fwd, vt[k].sel, 1'b0);
      tick();
    end

    sel = 3'd0;
    step("direct_sel0", 1'b1, 3'd0, 1'b0);
    mode = 1'b1; dwell = 4'd0;
    for (int k = 0; k <= 16; k++)
      step("scan_dwell0", 1'b1, 3'(k % 8), (k > 0) && (k % 8 == 0));

    dwell = 4'd2;
    for (int j = 1; j <= 26; j++)
      step("scan_dwell2", 1'b1, 3'((j / 3) % 8), j == 24);

    dwell = 4'd0;
    step("dwell_drop", 1'b1, 3'd1, 1'b0);
    step("dwell_drop", 1'b1, 3'd2, 1'b0);

    mode = 1'b0; sel = 3'd5;
    step("direct_sel5", 1'b1, 3'd5, 1'b0);
    mode = 1'b1; dwell = 4'd1;
    step("mode_switch", 1'b1, 3'd5, 1'b0);
    step("mode_switch", 1'b1, 3'd5, 1'b0);
    step("mode_switch", 1'b1, 3'd6, 1'b0);
    step("mode_switch", 1'b1, 3'd6, 1'b0);
    step("mode_switch", 1'b1, 3'd7, 1'b0);
    step("mode_switch", 1'b1, 3'd7, 1'b0);
    step("mode_switch_wrap", 1'b1, 3'd0, 1'b1);
    step("mode_switch", 1'b1, 3'd0, 1'b0);

    step("scan_to3", 1'b1, 3'd1, 1'b0);
    step("scan_to3", 1'b1, 3'd1, 1'b0);
    step("scan_to3", 1'b1, 3'd2, 1'b0);
    step("scan_to3", 1'b1, 3'd2, 1'b0);
    step("scan_to3", 1'b1, 3'd3, 1'b0);
    en = 1'b0;
    step("mid_scan_disable", 1'b0, 3'd3, 1'b0);
    step("mid_scan_disable", 1'b0, 3'd3, 1'b0);
    en = 1'b1;
    step("resume", 1'b1, 3'd3, 1'b0);
    step("resume", 1'b1, 3'd3, 1'b0);
    step("resume", 1'b1, 3'd4, 1'b0);

    #3;
    rst_n = 1'b0;
    #1;
    check_idx("async_reset", 1'b0, 3'd0, 1'b0);
    #1;
    rst_n = 1'b1;
    step("post_reset_entry", 1'b1, 3'd0, 1'b0);
    step("post_reset_entry", 1'b1, 3'd0, 1'b0);
    step("post_reset_scan", 1'b1, 3'd1, 1'b0);

    total++;
    if (sbq.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sbq.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered one-hot line decoder with enable, selectable output ordering, and an auto-scan mode. In scan mode a dwell counter steps the active line through all outputs, for use as a digit/row strobe generator. Direct mode decodes an external select. It replaces hand-built fixed-width gate decoders wherever a clocked strobe or scanner is needed.

## Interface
Parameters:
- SEL_W, 3, select/index width; output count N = 2**SEL_W (legal 1..6)
- DWELL_W, 4, width of dwell setting
- REVERSE, 1, 1: index i drives d[N-1-i] (legacy ordering); 0: index i drives d[i]

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  enable; 0 forces all outputs low
- mode  in  1  0 = direct decode, 1 = auto-scan
- sel  in  SEL_W  select index (direct mode only)
- dwell  in  DWELL_W  extra hold cycles per index in scan mode; sampled every cycle
- d  out  N  registered one-hot strobe (all-zero when disabled)
- idx  out  SEL_W  registered current index
- wrap  out  1  one-cycle pulse when scan wraps N-1 -> 0

## Operation
- Internal state register st ∈ {IDLE, DIRECT, SCAN}; dwell counter cnt (DWELL_W bits).
- Reset (rst_n=0, asynchronous): st=IDLE, d=0, idx=0, cnt=0, wrap=0.
- map(i) = REVERSE ? N-1-i : i; d always equals onehot(map(idx)) when enabled, else 0.
- Next-state each edge: en=0 -> IDLE; en=1 & mode=0 -> DIRECT; en=1 & mode=1 -> SCAN.
- en=0: d<=0, idx holds, cnt<=0, wrap<=0.
- en=1, mode=0: idx<=sel, d<=onehot(map(sel)), cnt<=0, wrap<=0.
- en=1, mode=1, entry (current st≠SCAN): idx holds, d<=onehot(map(idx)), cnt<=0, wrap<=0.
- en=1, mode=1, st=SCAN:
  - cnt<dwell: cnt<=cnt+1, idx holds, wrap<=0.
  - cnt>=dwell: cnt<=0, idx<=(idx+1) mod N, d updated to match, wrap<=(idx==N-1).
- dwell lowered below the current cnt: treated as cnt>=dwell, advance on the next edge.
- Index arithmetic is SEL_W-bit unsigned, natural wrap; never produces a non-one-hot d.
- Mode changes take effect on the next edge; direct->scan starts scanning from the last direct sel.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Direct-mode latency: sel to d/idx = 1 cycle.
- Disable latency: en fall to d=0 = 1 cycle; re-enable shows a valid strobe 1 cycle later.
- Scan: each index, including the entry index, is visible for exactly dwell+1 cycles. A full sweep takes N*(dwell+1) cycles.
- wrap is high for exactly the one cycle in which idx=0 after an N-1 -> 0 advance. It is never asserted in direct mode or on scan entry at idx=0.
- Reset asserted mid-scan clears all outputs immediately (asynchronous). On deassertion, the first enabled scan edge is an entry edge at idx=0.

## Test plan
- Reset/disable: rst_n=0 with en=1, mode=1 -> d=0, idx=0, wrap=0 immediately. Release with en=0 -> d stays 0 for 5 cycles.
- Direct decode, SEL_W=3, REVERSE=1: sel=0..7 one per cycle -> one cycle later d=8'h80,40,20,10,08,04,02,01. Same with REVERSE=0 -> d=8'h01..8'h80.
- Scan, dwell=0, N=8, start idx=0: d advances every cycle. idx=7 -> 0 produces wrap=1 for one cycle, every 8 cycles.
- Scan, dwell=2: each index is held 3 cycles; the sweep period is 24 cycles. Changing dwell 2 -> 0 while cnt=2 advances on the next edge.
- Mode switch: direct sel=5, then mode=1 with dwell=1 -> idx=5 for 2 cycles, then 6, 7, 0 (wrap=1 with idx=0).
- Mid-scan disruption: en=0 at idx=3 -> d=0 next cycle, idx stays 3. en=1 -> resumes at idx=3 for dwell+1 cycles. An async rst_n pulse mid-scan -> all outputs 0 without waiting for a clock edge.
